// File: rtl/trading_pkg.sv
// trading_pkg: shared quote/order types and the per-side change filter
package trading_pkg;
  localparam int TP_DATA_W     = 32;
  localparam int TP_NUM_STOCKS = 4;
  localparam int TP_STOCK_W    = $clog2(TP_NUM_STOCKS);
  typedef enum logic {SIDE_BUY = 1'b0, SIDE_SELL = 1'b1} order_side_e;
  typedef enum logic [1:0] {IDLE, BUY, SELL} ogen_state_e;
  typedef struct packed {
    logic [TP_STOCK_W-1:0] stock_id;
    logic [TP_DATA_W-1:0]  buy;
    logic [TP_DATA_W-1:0]  sell;
    logic                  need_buy;
    logic                  need_sell;
  } quote_entry_t;
  // A side is re-sent when it carries a price and moved at least min_delta from the last enqueued one;
  // the extra bit keeps the difference from wrapping.
  function automatic logic side_needed(input logic [TP_DATA_W-1:0] price, input logic [TP_DATA_W-1:0] last,
                                       input logic last_valid, input logic [TP_DATA_W:0] min_delta);
    logic [TP_DATA_W:0] p, l, d;
    p = {1'b0, price};
    l = {1'b0, last};
    d = (p >= l) ? p - l : l - p;
    return (price != '0) && (!last_valid || d >= min_delta);
  endfunction
endpackage

// File: rtl/quote_order_gen_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with occupancy count and async reset
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // storage is written only, never reset
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wr_q] <= din_i;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/quote_order_gen.sv
// quote_order_gen: filters per-stock quote changes, buffers them and serialises single-side orders
module quote_order_gen
  import trading_pkg::*;
#(
  parameter int DATA_WIDTH = TP_DATA_W,
  parameter int NUM_STOCKS = TP_NUM_STOCKS,
  parameter int FIFO_DEPTH = 8,
  parameter int MIN_DELTA  = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [DATA_WIDTH-1:0]         i_buy_price,
  input  logic [DATA_WIDTH-1:0]         i_sell_price,
  input  logic                          i_data_valid,
  input  logic [$clog2(NUM_STOCKS)-1:0] i_stock_id,
  output logic                          o_order_valid,
  input  logic                          i_order_ready,
  output logic                          o_order_side,
  output logic [$clog2(NUM_STOCKS)-1:0] o_order_stock_id,
  output logic [DATA_WIDTH-1:0]         o_order_price,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic [CNT_WIDTH-1:0]          o_drop_count
);
  logic [DATA_WIDTH-1:0] tbl_buy_q [NUM_STOCKS];
  logic [DATA_WIDTH-1:0] tbl_sell_q [NUM_STOCKS];
  logic [NUM_STOCKS-1:0] tbl_valid_q;
  logic need_buy, need_sell, take, push, drop, pop, fifo_full, fifo_empty;
  quote_entry_t in_entry, head;
  ogen_state_e state_q;
  order_side_e side_q;
  logic valid_q;
  logic [$clog2(NUM_STOCKS)-1:0] stock_q;
  logic [DATA_WIDTH-1:0] price_q;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;
  assign need_buy  = side_needed(i_buy_price, tbl_buy_q[i_stock_id], tbl_valid_q[i_stock_id],
                                 (DATA_WIDTH+1)'(MIN_DELTA));
  assign need_sell = side_needed(i_sell_price, tbl_sell_q[i_stock_id], tbl_valid_q[i_stock_id],
                                 (DATA_WIDTH+1)'(MIN_DELTA));
  assign take = i_data_valid && (need_buy || need_sell);
  assign push = take && !fifo_full;
  assign drop = take && fifo_full;
  assign pop  = valid_q && i_order_ready && (state_q == SELL || (state_q == BUY && !head.need_sell));
  assign drop_d = (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
  // assemble the FIFO word for the incoming quote
  always_comb begin
    in_entry.stock_id  = i_stock_id;
    in_entry.buy       = i_buy_price;
    in_entry.sell      = i_sell_price;
    in_entry.need_buy  = need_buy;
    in_entry.need_sell = need_sell;
  end
  sync_fifo #(.WIDTH($bits(quote_entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (i_reset),
    .push_i  (push),
    .din_i   (in_entry),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (o_fifo_count)
  );
  // remember the last enqueued price per side so later quotes filter against it
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      tbl_valid_q <= '0;
      for (int i = 0; i < NUM_STOCKS; i++) begin
        tbl_buy_q[i]  <= '0;
        tbl_sell_q[i] <= '0;
      end
    end else if (push) begin
      tbl_valid_q[i_stock_id] <= 1'b1;
      if (need_buy) tbl_buy_q[i_stock_id] <= i_buy_price;
      if (need_sell) tbl_sell_q[i_stock_id] <= i_sell_price;
    end
  // count quotes lost to a full FIFO, saturating
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) drop_q <= '0;
    else drop_q <= drop_d;
  // order serialiser: buy then sell per entry, outputs held until handshake
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      side_q  <= SIDE_BUY;
      stock_q <= '0;
      price_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (!fifo_empty) begin
          valid_q <= 1'b1;
          stock_q <= head.stock_id;
          state_q <= head.need_buy ? BUY : SELL;
          side_q  <= head.need_buy ? SIDE_BUY : SIDE_SELL;
          price_q <= head.need_buy ? head.buy : head.sell;
        end
        BUY: if (i_order_ready) begin
          if (head.need_sell) begin
            state_q <= SELL;
            side_q  <= SIDE_SELL;
            price_q <= head.sell;
          end else begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        SELL: if (i_order_ready) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign o_order_valid    = valid_q;
  assign o_order_side     = side_q;
  assign o_order_stock_id = stock_q;
  assign o_order_price    = price_q;
  assign o_drop_count     = drop_q;
endmodule

// File: tb/tb_quote_order_gen.sv
// tb_quote_order_gen: directed scenarios plus random traffic against a queue-based reference model
module tb_quote_order_gen;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] buy_p = '0;
  logic [31:0] sell_p = '0;
  logic dv = 1'b0;
  logic rdy = 1'b0;
  logic [1:0] sid = '0;
  logic o_valid, o_side;
  logic [1:0] o_stock;
  logic [31:0] o_price;
  logic [3:0] o_count;
  logic [15:0] o_drop;
  always #5 clk = ~clk;
  quote_order_gen dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_buy_price      (buy_p),
    .i_sell_price     (sell_p),
    .i_data_valid     (dv),
    .i_stock_id       (sid),
    .o_order_valid    (o_valid),
    .i_order_ready    (rdy),
    .o_order_side     (o_side),
    .o_order_stock_id (o_stock),
    .o_order_price    (o_price),
    .o_fifo_count     (o_count),
    .o_drop_count     (o_drop)
  );
  typedef struct {
    logic side;
    logic [1:0] stock;
    logic [31:0] price;
    bit last;
  } ord_t;
  ord_t exp_q[$];
  longint m_buy[4];
  longint m_sell[4];
  bit m_val[4];
  int occ, drops;
  int n_chk = 0;
  int n_pass = 0;
  logic obs_valid, obs_side;
  logic [1:0] obs_stock;
  logic [31:0] obs_price;
  bit stall;
  logic st_side;
  logic [1:0] st_stock;
  logic [31:0] st_price;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit needed(input longint p, input longint last, input bit v);
    longint d;
    d = (p > last) ? p - last : last - p;
    return p != 0 && (!v || d >= 1);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    occ = 0;
    drops = 0;
    stall = 0;
    for (int i = 0; i < 4; i++) begin
      m_buy[i] = 0;
      m_sell[i] = 0;
      m_val[i] = 0;
    end
  endfunction

  function automatic logic [31:0] rp();
    int r;
    r = $urandom_range(0, 7);
    return r == 0 ? 32'd0 : r == 1 ? 32'hFFFF_FFFF : 32'(1000 + $urandom_range(0, 2));
  endfunction

  task automatic step(input int v, input int id, input logic [31:0] b, input logic [31:0] s, input int r);
    bit nb, ns, hs;
    logic [1:0] idl;
    ord_t o;
    @(negedge clk);
    obs_valid = o_valid;
    obs_side  = o_side;
    obs_stock = o_stock;
    obs_price = o_price;
    check("fifo_count", o_count, occ);
    check("drop_count", o_drop, drops);
    if (stall) begin
      check("hold_valid", o_valid, 1);
      check("hold_side", o_side, st_side);
      check("hold_stock", o_stock, st_stock);
      check("hold_price", o_price, st_price);
    end
    idl = 2'(id);
    rdy = r != 0;
    dv = v != 0;
    sid = idl;
    buy_p = b;
    sell_p = s;
    nb = needed(b, m_buy[idl], m_val[idl]);
    ns = needed(s, m_sell[idl], m_val[idl]);
    if (v != 0 && (nb || ns)) begin
      if (occ == DEPTH) begin
        if (drops != 16'hFFFF) drops++;
      end else begin
        if (nb) begin
          o.side = 1'b0; o.stock = idl; o.price = b; o.last = !ns;
          exp_q.push_back(o);
          m_buy[idl] = b;
        end
        if (ns) begin
          o.side = 1'b1; o.stock = idl; o.price = s; o.last = 1;
          exp_q.push_back(o);
          m_sell[idl] = s;
        end
        m_val[idl] = 1;
        occ++;
      end
    end
    hs = o_valid && r != 0;
    if (hs) begin
      if (exp_q.size() == 0) check("spurious_order", 1, 0);
      else begin
        o = exp_q.pop_front();
        check("order_side", o_side, o.side);
        check("order_stock", o_stock, o.stock);
        check("order_price", o_price, o.price);
        if (o.last) occ--;
      end
    end
    stall = o_valid && r == 0;
    st_side = o_side;
    st_stock = o_stock;
    st_price = o_price;
  endtask

  task automatic idle(input int n, input int r);
    repeat (n) step(0, 0, 0, 0, r);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    dv = 1'b0;
    #1;
    check("rst_valid_async", o_valid, 0);
    check("rst_count", o_count, 0);
    check("rst_drop", o_drop, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    @(negedge clk);
    check("init_valid", o_valid, 0);
    check("init_count", o_count, 0);
    check("init_drop", o_drop, 0);
    check("init_price", o_price, 0);
    @(negedge clk);
    rst = 1'b0;
    // basic two-sided quote and its latency
    step(1, 2, 1000, 1010, 1);
    step(0, 0, 0, 0, 1);
    check("t1_n1_valid", obs_valid, 0);
    step(0, 0, 0, 0, 1);
    check("t1_n2_valid", obs_valid, 1);
    check("t1_n2_side", obs_side, 0);
    check("t1_n2_price", obs_price, 1000);
    step(0, 0, 0, 0, 1);
    check("t1_n3_valid", obs_valid, 1);
    check("t1_n3_side", obs_side, 1);
    check("t1_n3_stock", obs_stock, 2);
    check("t1_n3_price", obs_price, 1010);
    idle(4, 1);
    check("t1_empty", o_count, 0);
    // re-quote: only the changed side, then no change at all
    step(1, 2, 1000, 1011, 1);
    idle(5, 1);
    step(1, 2, 1000, 1011, 1);
    step(0, 0, 0, 0, 1);
    check("t2_no_write", o_count, 0);
    idle(3, 1);
    // overflow with a stalled consumer
    for (int i = 0; i < 9; i++) step(1, i % 4, 32'(2000 + i), 32'(3000 + i), 0);
    step(0, 0, 0, 0, 0);
    check("t3_full", o_count, 8);
    check("t3_drop", o_drop, 1);
    idle(60, 1);
    step(1, 0, 2004, 3008, 1);
    idle(6, 1);
    // ready toggling while an order is presented
    step(1, 3, 700, 710, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, i % 2);
    idle(6, 1);
    // single-sided quotes and the no-wrap difference
    step(1, 1, 0, 500, 1);
    idle(5, 1);
    step(1, 1, 1, 500, 1);
    idle(5, 1);
    step(1, 1, 32'hFFFF_FFFF, 500, 1);
    idle(5, 1);
    // reset while a sell is presented with three entries queued
    step(1, 0, 100, 200, 0);
    step(1, 1, 110, 210, 0);
    step(1, 3, 120, 220, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check("t6_pre_valid", o_valid, 1);
    check("t6_pre_side", o_side, 1);
    check("t6_pre_count", o_count, 3);
    do_reset();
    step(1, 2, 1000, 1010, 1);
    step(1, 0, 100, 200, 1);
    idle(10, 1);
    // random traffic
    repeat (3000) step($urandom_range(0, 1), $urandom_range(0, 3), rp(), rp(), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 300 && (exp_q.size() != 0 || o_valid); i++) step(0, 0, 0, 0, 1);
    check("drain_done", exp_q.size(), 0);
    check("drain_count", o_count, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
